// File: rtl/z80_bus_bridge.sv
// Z80 strobe bus to level-request fabric bridge; mem_req rises 1 clk after access start.
// Backpressure: wait_n held low until mem_ack or WAIT_LIMIT timeout abandons the access.
// Option: define Z80_BUS_BRIDGE_M1WAIT_EN to add one wait clk after an acked M1 read.
module z80_bus_bridge #(
  parameter int         WAIT_LIMIT = 255,
  parameter logic [7:0] IDLE_DATA  = 8'hFF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mreq_n_i,
  input  logic        iorq_n_i,
  input  logic        rd_n_i,
  input  logic        wr_n_i,
  input  logic        m1_n_i,
  input  logic [15:0] a_i,
  input  logic [7:0]  cpu_dout_i,
  input  logic [7:0]  int_vec_i,
  output logic [7:0]  cpu_di_o,
  output logic        wait_n_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_io_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        timeout_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_M1X  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [7:0] TERM_CNT = 8'(WAIT_LIMIT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        strobe_q, inta_q;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_io_q, mem_io_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [7:0]  cpu_di_q, cpu_di_d;

  logic        strobe, inta, start, inta_start;
  logic        term_hit, m1_stall;
  logic [1:0]  after_access;

  // Refresh (mreq low, no rd/wr) never qualifies as a strobe.
  assign strobe     = (~mreq_n_i | ~iorq_n_i) & (~rd_n_i | ~wr_n_i);
  assign inta       = ~iorq_n_i & ~m1_n_i;
  assign start      = strobe & ~strobe_q;
  assign inta_start = inta & ~inta_q;

  assign term_hit   = (state_q == ST_BUSY) && (cnt_q == TERM_CNT);

`ifdef Z80_BUS_BRIDGE_M1WAIT_EN
  assign m1_stall = ~mem_we_q & ~m1_n_i;
`else
  assign m1_stall = 1'b0;
`endif

  // A CPU that already dropped its strobe has nothing left to hold in DONE.
  assign after_access = (strobe | inta) ? ST_DONE : ST_IDLE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_io_d    = mem_io_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_di_d    = cpu_di_q;
    case (state_q)
      ST_IDLE: begin
        if (inta_start) begin
          cpu_di_d = int_vec_i;
          state_d  = ST_DONE;
        end else if (start) begin
          mem_addr_d  = a_i;
          mem_we_d    = ~wr_n_i;
          mem_io_d    = ~iorq_n_i;
          mem_wdata_d = cpu_dout_i;
          mem_req_d   = 1'b1;
          cnt_d       = 8'd0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Ack takes priority over the terminal count in the same clk.
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) cpu_di_d = mem_rdata_i;
          state_d = m1_stall ? ST_M1X : after_access;
        end else if (term_hit) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) cpu_di_d = IDLE_DATA;
          state_d = after_access;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_M1X: begin
        state_d = after_access;
      end
      ST_DONE: begin
        if (!strobe && !inta) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      strobe_q    <= 1'b0;
      inta_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_io_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      cpu_di_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      strobe_q    <= strobe;
      inta_q      <= inta;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_io_q    <= mem_io_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_di_q    <= cpu_di_d;
    end
  end

  // Wait is asserted in the start clk itself so the CPU never samples it late.
  always_comb begin
    wait_n_o = 1'b1;
    case (state_q)
      ST_IDLE:         wait_n_o = ~(start | inta_start);
      ST_BUSY, ST_M1X: wait_n_o = 1'b0;
      default:         wait_n_o = 1'b1;
    endcase
  end

  assign timeout_o   = term_hit & ~mem_ack_i;
  assign cpu_di_o    = cpu_di_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_io_o    = mem_io_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Directed bench for z80_bus_bridge: default instance plus a WAIT_LIMIT=4 instance for timeouts.
module tb_z80_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;
  logic [15:0] a;
  logic [7:0]  cpu_dout, int_vec, mem_rdata;
  logic        mem_ack, mem_ack4;

  logic [7:0]  cpu_di, cpu_di4;
  logic        wait_n, wait_n4;
  logic        mem_req, mem_req4;
  logic        mem_we, mem_we4;
  logic        mem_io, mem_io4;
  logic [15:0] mem_addr, mem_addr4;
  logic [7:0]  mem_wdata, mem_wdata4;
  logic        timeout, timeout4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  z80_bus_bridge dut (
    .clk_i(clk), .reset_i(reset),
    .mreq_n_i(mreq_n), .iorq_n_i(iorq_n), .rd_n_i(rd_n), .wr_n_i(wr_n), .m1_n_i(m1_n),
    .a_i(a), .cpu_dout_i(cpu_dout), .int_vec_i(int_vec),
    .cpu_di_o(cpu_di), .wait_n_o(wait_n), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_io_o(mem_io), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .timeout_o(timeout)
  );

  z80_bus_bridge #(.WAIT_LIMIT(4), .IDLE_DATA(8'hFF)) dut4 (
    .clk_i(clk), .reset_i(reset),
    .mreq_n_i(mreq_n), .iorq_n_i(iorq_n), .rd_n_i(rd_n), .wr_n_i(wr_n), .m1_n_i(m1_n),
    .a_i(a), .cpu_dout_i(cpu_dout), .int_vec_i(int_vec),
    .cpu_di_o(cpu_di4), .wait_n_o(wait_n4), .mem_req_o(mem_req4), .mem_we_o(mem_we4),
    .mem_io_o(mem_io4), .mem_addr_o(mem_addr4), .mem_wdata_o(mem_wdata4),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack4), .timeout_o(timeout4)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus_idle(); a = 16'hFFFF; cpu_dout = 8'hAA; int_vec = 8'h00;
    mem_rdata = 8'h00; mem_ack = 1'b0; mem_ack4 = 1'b0;
    step(); step();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", mem_we); end
    total++; if (mem_io !== 1'b0) begin bad++; $display("FAIL rst_io got=%b want=0", mem_io); end
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h want=0000", mem_addr); end
    total++; if (mem_wdata !== 8'h00) begin bad++; $display("FAIL rst_wdata got=%h want=00", mem_wdata); end
    total++; if (cpu_di !== 8'h00) begin bad++; $display("FAIL rst_cpu_di got=%h want=00", cpu_di); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", timeout); end
    total++; if (wait_n !== 1'b1) begin bad++; $display("FAIL rst_wait got=%b want=1", wait_n); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_mem_read;
    int hi;
    mreq_n = 1'b0; rd_n = 1'b0; a = 16'h1234; #1;
    total++; if (wait_n !== 1'b0) begin bad++; $display("FAIL rd_start_wait got=%b want=0", wait_n); end
    hi = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      mem_ack = (i == 4); mem_rdata = 8'h5A;
      if (mem_req) hi++;
      #1;
      if (i == 1) begin
        total++; if (mem_addr !== 16'h1234) begin bad++; $display("FAIL rd_addr got=%h want=1234", mem_addr); end
        total++; if (mem_io !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL rd_io_we got=%b%b want=00", mem_io, mem_we); end
      end
      total++;
      if (wait_n !== ((i <= 4) ? 1'b0 : 1'b1)) begin
        bad++; $display("FAIL rd_wait clk=%0d got=%b want=%b", i, wait_n, (i <= 4) ? 1'b0 : 1'b1);
      end
    end
    total++; if (hi != 4) begin bad++; $display("FAIL rd_req_len got=%0d want=4", hi); end
    total++; if (cpu_di !== 8'h5A) begin bad++; $display("FAIL rd_data got=%h want=5A", cpu_di); end
    mem_ack = 1'b0; bus_idle();
    step(); step();
  endtask

  task automatic test_io_write;
    iorq_n = 1'b0; wr_n = 1'b0; a = 16'h00FE; cpu_dout = 8'hC3;
    step();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL wr_req got=%b want=1", mem_req); end
    total++; if (mem_io !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL wr_io_we got=%b%b want=11", mem_io, mem_we); end
    total++; if (mem_wdata !== 8'hC3) begin bad++; $display("FAIL wr_wdata got=%h want=C3", mem_wdata); end
    total++; if (mem_addr !== 16'h00FE) begin bad++; $display("FAIL wr_addr got=%h want=00FE", mem_addr); end
    a = 16'h5555; cpu_dout = 8'h00;
    step();
    mem_ack = 1'b1; #1;
    total++; if (mem_addr !== 16'h00FE || mem_wdata !== 8'hC3) begin bad++; $display("FAIL wr_stable got=%h/%h want=00FE/C3", mem_addr, mem_wdata); end
    total++; if (wait_n !== 1'b0) begin bad++; $display("FAIL wr_ack_wait got=%b want=0", wait_n); end
    step();
    mem_ack = 1'b0; #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL wr_req_drop got=%b want=0", mem_req); end
    total++; if (cpu_di !== 8'h5A) begin bad++; $display("FAIL wr_cpu_di_hold got=%h want=5A", cpu_di); end
    total++; if (wait_n !== 1'b1) begin bad++; $display("FAIL wr_done_wait got=%b want=1", wait_n); end
    bus_idle();
    step(); step();
  endtask

  task automatic test_inta_refresh;
    int_vec = 8'hFF; iorq_n = 1'b0; m1_n = 1'b0; #1;
    total++; if (wait_n !== 1'b0) begin bad++; $display("FAIL inta_start_wait got=%b want=0", wait_n); end
    step();
    total++; if (cpu_di !== 8'hFF) begin bad++; $display("FAIL inta_vec got=%h want=FF", cpu_di); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL inta_req got=%b want=0", mem_req); end
    total++; if (wait_n !== 1'b1) begin bad++; $display("FAIL inta_wait1 got=%b want=1", wait_n); end
    step();
    total++; if (wait_n !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL inta_hold got=%b%b want=10", wait_n, mem_req); end
    bus_idle();
    step();
    mreq_n = 1'b0; #1;
    total++; if (wait_n !== 1'b1) begin bad++; $display("FAIL rfsh_wait got=%b want=1", wait_n); end
    step();
    total++; if (mem_req !== 1'b0 || wait_n !== 1'b1) begin bad++; $display("FAIL rfsh_req got=%b%b want=01", mem_req, wait_n); end
    step();
    total++; if (cpu_di !== 8'hFF || mem_req !== 1'b0) begin bad++; $display("FAIL rfsh_hold got=%h/%b want=FF/0", cpu_di, mem_req); end
    bus_idle();
    step();
    mem_ack = 1'b1; mem_rdata = 8'h77;
    step();
    mem_ack = 1'b0;
    step();
    total++; if (cpu_di !== 8'hFF || mem_req !== 1'b0) begin bad++; $display("FAIL idle_ack got=%h/%b want=FF/0", cpu_di, mem_req); end
  endtask

  task automatic test_ack_at_terminal;
    int pulses;
    pulses = 0;
    mreq_n = 1'b0; rd_n = 1'b0; a = 16'h4001; mem_rdata = 8'h3C;
    for (int i = 1; i <= 5; i++) begin
      step();
      mem_ack4 = (i == 4); mem_ack = (i == 4);
      #1;
      if (timeout4) pulses++;
      if (i == 5) begin
        total++; if (cpu_di4 !== 8'h3C) begin bad++; $display("FAIL term_ack_data got=%h want=3C", cpu_di4); end
        total++; if (mem_req4 !== 1'b0 || wait_n4 !== 1'b1) begin bad++; $display("FAIL term_ack_req got=%b%b want=01", mem_req4, wait_n4); end
      end
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL term_ack_timeout got=%0d want=0", pulses); end
    mem_ack4 = 1'b0; mem_ack = 1'b0; bus_idle();
    step(); step();
  endtask

  task automatic test_timeout;
    int pulses, at;
    pulses = 0; at = 0;
    mreq_n = 1'b0; rd_n = 1'b0; a = 16'h4000; mem_rdata = 8'h11;
    for (int i = 1; i <= 6; i++) begin
      step();
      mem_ack = (i == 5);
      #1;
      if (timeout4) begin pulses++; at = i; end
      if (i == 4) begin
        total++; if (mem_req4 !== 1'b1) begin bad++; $display("FAIL to_req_busy got=%b want=1", mem_req4); end
      end
      if (i == 5) begin
        total++; if (mem_req4 !== 1'b0) begin bad++; $display("FAIL to_req_drop got=%b want=0", mem_req4); end
        total++; if (cpu_di4 !== 8'hFF) begin bad++; $display("FAIL to_idle_data got=%h want=FF", cpu_di4); end
        total++; if (wait_n4 !== 1'b1) begin bad++; $display("FAIL to_wait got=%b want=1", wait_n4); end
      end
    end
    total++; if (pulses != 1 || at != 4) begin bad++; $display("FAIL to_pulse got=%0d@%0d want=1@4", pulses, at); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_main_no_timeout got=%b want=0", timeout); end
    mem_ack = 1'b0; bus_idle();
    step(); step();
  endtask

  task automatic test_reset_mid;
    mreq_n = 1'b0; wr_n = 1'b0; a = 16'hABCD; cpu_dout = 8'h99;
    step(); step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'hABCD) begin bad++; $display("FAIL rm_pre got=%b/%h want=1/ABCD", mem_req, mem_addr); end
    reset = 1'b1; bus_idle();
    step();
    reset = 1'b0; #1;
    total++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_io !== 1'b0) begin bad++; $display("FAIL rm_ctl got=%b%b%b want=000", mem_req, mem_we, mem_io); end
    total++; if (mem_addr !== 16'h0000 || mem_wdata !== 8'h00) begin bad++; $display("FAIL rm_bus got=%h/%h want=0000/00", mem_addr, mem_wdata); end
    total++; if (cpu_di !== 8'h00 || timeout !== 1'b0 || wait_n !== 1'b1) begin bad++; $display("FAIL rm_out got=%h/%b/%b want=00/0/1", cpu_di, timeout, wait_n); end
    step();
    mreq_n = 1'b0; rd_n = 1'b0; a = 16'h0042;
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0042) begin bad++; $display("FAIL rm_new_req got=%b/%h want=1/0042", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 8'h66;
    step();
    mem_ack = 1'b0; #1;
    total++; if (cpu_di !== 8'h66 || mem_req !== 1'b0) begin bad++; $display("FAIL rm_new_done got=%h/%b want=66/0", cpu_di, mem_req); end
    total++; if (wait_n !== 1'b1) begin bad++; $display("FAIL rm_new_wait got=%b want=1", wait_n); end
    bus_idle();
    step(); step();
  endtask

  task automatic test_m1_fetch;
    logic exp_w3;
`ifdef Z80_BUS_BRIDGE_M1WAIT_EN
    exp_w3 = 1'b0;
`else
    exp_w3 = 1'b1;
`endif
    mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0; a = 16'h0000;
    step();
    step();
    mem_ack = 1'b1; mem_rdata = 8'h31; #1;
    total++; if (wait_n !== 1'b0) begin bad++; $display("FAIL m1_ack_wait got=%b want=0", wait_n); end
    step();
    mem_ack = 1'b0; #1;
    total++; if (wait_n !== exp_w3) begin bad++; $display("FAIL m1_post_ack_wait got=%b want=%b", wait_n, exp_w3); end
    total++; if (cpu_di !== 8'h31) begin bad++; $display("FAIL m1_data got=%h want=31", cpu_di); end
    step();
    total++; if (wait_n !== 1'b1) begin bad++; $display("FAIL m1_release got=%b want=1", wait_n); end
    bus_idle();
    step(); step();
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_io_write();
    test_inta_refresh();
    test_ack_at_terminal();
    test_timeout();
    test_reset_mid();
    test_m1_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/z80_bus_bridge.md
Z80_BUS_BRIDGE -- requirements
Module: z80_bus_bridge

Interface
REQ-001 Parameter WAIT_LIMIT, default 255, BUSY-state clk count after which an access is abandoned (legal range 2..255).
REQ-002 Parameter IDLE_DATA, default 8'hFF, data returned to the CPU on a timed-out read.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 mreq_n, iorq_n, rd_n, wr_n, m1_n  in  1 each  CPU bus strobes, active-low.
REQ-007 A  in  16  CPU address.
REQ-008 cpu_dout  in  8  CPU write data.
REQ-009 int_vec  in  8  vector returned during interrupt acknowledge.
REQ-010 cpu_di  out  8  registered read data to the CPU.
REQ-011 wait_n  out  1  CPU wait request, active-low.
REQ-012 mem_req  out  1  registered request to the memory/IO fabric.
REQ-013 mem_we  out  1  1 = write, 0 = read.
REQ-014 mem_io  out  1  1 = IO space, 0 = memory space.
REQ-015 mem_addr  out  16  registered address.
REQ-016 mem_wdata  out  8  registered write data.
REQ-017 mem_rdata  in  8  fabric read data, valid with mem_ack.
REQ-018 mem_ack  in  1  one-clk completion pulse from the fabric.
REQ-019 timeout  out  1  one-clk pulse on abandoned access.

Function
REQ-020 Access strobe = (~mreq_n | ~iorq_n) & (~rd_n | ~wr_n); start = strobe high this clk and low the previous clk; evaluated every clk.
REQ-021 INTA = ~iorq_n & ~m1_n; the INTA start is its rising edge.
REQ-022 A refresh cycle (mreq_n low, rd_n and wr_n high) is not an access and is ignored.
REQ-023 States: IDLE, BUSY, M1X, DONE.
REQ-024 IDLE + start: latch mem_addr=A, mem_we=~wr_n, mem_io=~iorq_n, mem_wdata=cpu_dout; mem_req=1; clear counter; go BUSY.
REQ-025 IDLE + INTA start: cpu_di=int_vec; no mem_req; go DONE.
REQ-026 BUSY + mem_ack: mem_req=0 the next clk; on a read, cpu_di=mem_rdata; go DONE (or M1X per REQ-035).
REQ-027 BUSY: counter increments each clk; when counter==WAIT_LIMIT-1 without ack, mem_req=0, cpu_di=IDLE_DATA on a read, timeout=1 for one clk; go DONE.
REQ-028 mem_ack and terminal count in the same clk: ack wins, no timeout.
REQ-029 mem_ack outside BUSY is ignored.
REQ-030 wait_n = 0 combinationally in any IDLE clk with start or INTA start, and in BUSY and M1X; otherwise 1.
REQ-031 DONE: hold cpu_di; return to IDLE in the first clk with strobe and INTA both low.
REQ-032 Strobe dropping during BUSY: the access still completes on ack/timeout; the FSM then goes directly to IDLE.
REQ-033 Request handshake: level request; mem_req stays high from entry to BUSY until the clk after ack/timeout; mem_addr/mem_we/mem_io/mem_wdata stay stable while mem_req=1.

Reset
REQ-034 reset forces IDLE from any state, including mid-access: mem_req=0, mem_we=0, mem_io=0, mem_addr=0, mem_wdata=0, cpu_di=8'h00, timeout=0, counter=0; wait_n=1.

Configuration
REQ-035 Macro Z80_BUS_BRIDGE_M1WAIT_EN: defined -> an acked read with m1_n low goes BUSY->M1X->DONE, adding one wait_n-low clk after ack; undefined -> M1X is unreachable and M1 fetches complete like other reads.

Verification
REQ-036 Memory read A=16'h1234, ack after 3 clks with rdata=8'h5A -> mem_req high 4 clks, mem_io=0, mem_we=0, cpu_di=8'h5A, wait_n high from the ack clk +1.
REQ-037 IO write A=16'h00FE, cpu_dout=8'hC3, ack after 1 clk -> mem_io=1, mem_we=1, mem_wdata=8'hC3, mem_addr=16'h00FE.
REQ-038 INTA with int_vec=8'hFF, then refresh strobe -> cpu_di=8'hFF, mem_req never asserts, wait_n low for exactly the start clk.
REQ-039 WAIT_LIMIT=4, no ack -> single timeout pulse at BUSY clk 4, cpu_di=8'hFF, mem_req low after; ack on the same clk as terminal count -> no timeout, rdata taken.
REQ-040 Reset asserted during BUSY -> next clk all outputs at reset values; a new read then completes normally.
REQ-041 M1 fetch, ack on clk 2, macro defined vs undefined -> wait_n released one clk later vs immediately.
